// File: rtl/apb_master_bridge.sv
// Purpose : valid/ready request/response stream -> APB master, one transfer in flight.
// Latency : accept at edge N, SETUP in cycle N+1, ACCESS in cycle N+2, rsp_valid from cycle N+3 (+1 per wait state).
// Backpr. : req_ready only in IDLE; rsp_valid/rsp_rdata/rsp_err hold until rsp_ready; APB held while pready=0.
//
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   req_valid/req_ready         request handshake; req_write/req_addr/req_wdata carry the transfer
//   rsp_valid/rsp_ready         response handshake; rsp_rdata (0 for writes), rsp_err (timeout abort)
//   outp_psel/penable/pwrite/paddr/pwdata   APB master outputs (all driven from registers)
//   outp_pready/outp_prdata     APB completer inputs, only looked at in ACCESS
//
// Optional: define APB_TIMEOUT_EN to abort an ACCESS phase after TIMEOUT_CYCLES
// consecutive pready=0 cycles (rsp_err=1, rsp_rdata=0). Without it ACCESS waits forever
// and rsp_err is constant 0.
module apb_master_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              outp_psel,
  output logic              outp_penable,
  output logic              outp_pwrite,
  output logic [ADDR_W-1:0] outp_paddr,
  output logic [DATA_W-1:0] outp_pwdata,
  input  logic              outp_pready,
  input  logic [DATA_W-1:0] outp_prdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_accept;   // request handshake this cycle
  logic w_done;     // ACCESS completes with pready
  logic w_abort;    // ACCESS abandoned by the watchdog
  logic w_timeout;  // watchdog limit reached this cycle

  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  // ---------------------------------------------------------------------------
  // Access watchdog
  // ---------------------------------------------------------------------------
`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_wait_cnt;

  // r_wait_cnt holds the number of pready=0 cycles already seen in this ACCESS
  // phase, so the limit is hit on the TIMEOUT_CYCLES-th such cycle. pready=1
  // on that same edge is excluded here, so completion takes priority.
  assign w_timeout = (r_state == S_ACCESS) && !outp_pready &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_wait_cnt <= '0;
    end else if ((r_state == S_ACCESS) && !outp_pready && !w_timeout) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end
`else
  // No watchdog in this build: the comparison is constant false, which keeps
  // the abort path below shared between both builds.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake outputs decode the registered state only, so there is no
  // combinational path from any input to any output.
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    outp_psel    = 1'b0;
    outp_penable = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        outp_psel   = 1'b1;
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        outp_psel    = 1'b1;
        outp_penable = 1'b1;
        if (outp_pready) begin
          w_done      = 1'b1;
          w_state_nxt = S_RESP;
        end else if (w_timeout) begin
          w_abort     = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // APB address/data/direction load only on accept, so they stay stable
  // through SETUP and ACCESS and keep their last value in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pwrite <= req_write;
        r_paddr  <= req_addr;
        r_pwdata <= req_wdata;
      end
      if (w_done) begin
        r_rsp_rdata <= r_pwrite ? '0 : outp_prdata;
        r_rsp_err   <= 1'b0;
      end else if (w_abort) begin
        r_rsp_rdata <= '0;
        r_rsp_err   <= 1'b1;
      end
      if ((r_state == S_RESP) && rsp_ready) begin
        r_rsp_err <= 1'b0;
      end
    end
  end

  assign outp_pwrite = r_pwrite;
  assign outp_paddr  = r_paddr;
  assign outp_pwdata = r_pwdata;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Purpose : self-checking bench for apb_master_bridge (vector table, hand sequences, random vs model).
// Latency : expects rsp_valid 2 edges after the accept edge plus one edge per wait state.
// Backpr. : exercises response backpressure with a pending request and a reset during ACCESS.
module tb_apb_master_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          outp_psel;
  logic          outp_penable;
  logic          outp_pwrite;
  logic [AW-1:0] outp_paddr;
  logic [DW-1:0] outp_pwdata;
  logic          outp_pready;
  logic [DW-1:0] outp_prdata;

  apb_master_bridge #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .outp_psel   (outp_psel),
    .outp_penable(outp_penable),
    .outp_pwrite (outp_pwrite),
    .outp_paddr  (outp_paddr),
    .outp_pwdata (outp_pwdata),
    .outp_pready (outp_pready),
    .outp_prdata (outp_prdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected result of one transfer, straight from the protocol rules.
  typedef struct {
    logic [DW-1:0] rdata;
    int            lat;
    logic          err;
  } exp_t;

  function automatic exp_t model(input logic wr, input logic [DW-1:0] pd, input int waits);
    exp_t e;
    e.err   = 1'b0;
    e.rdata = wr ? '0 : pd;
    e.lat   = 2 + waits;
`ifdef APB_TIMEOUT_EN
    if (waits >= TO) begin
      e.err   = 1'b1;
      e.rdata = '0;
      e.lat   = 1 + TO;
    end
`endif
    return e;
  endfunction

  // Runs one transfer with an emulated completer inserting 'waits' wait states,
  // then holds the response for 'hold' cycles (with a junk request pending).
  // 'ok' collects every per-cycle protocol rule; lat counts edges from the
  // accept edge to the first cycle with rsp_valid.
  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int waits, input logic [DW-1:0] pd, input int hold,
                      output logic [DW-1:0] rd, output int lat, output logic err,
                      output logic ok, output int acc_cyc);
    int guard;
    int wseen;
    ok = 1'b1; lat = 0; wseen = 0; guard = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    while (!req_ready && guard < 50) begin
      step();
      guard++;
    end
    if (!req_ready) ok = 1'b0;
    step();
    acc_cyc = cyc;
    // Request fields must be ignored from here on.
    req_valid = 1'($urandom_range(0, 1));
    req_write = ~wr; req_addr = $urandom; req_wdata = $urandom;
    if (!(outp_psel && !outp_penable) || outp_paddr !== a || outp_pwrite !== wr ||
        outp_pwdata !== d || req_ready || rsp_valid) ok = 1'b0;
    outp_pready = 1'($urandom_range(0, 1));
    outp_prdata = $urandom;
    rsp_ready   = 1'($urandom_range(0, 1));
    while (lat < 40) begin
      step();
      lat++;
      if (rsp_valid) break;
      if (!(outp_psel && outp_penable) || outp_paddr !== a || outp_pwrite !== wr ||
          outp_pwdata !== d || req_ready) ok = 1'b0;
      rsp_ready = 1'($urandom_range(0, 1));
      if (wseen < waits) begin
        outp_pready = 1'b0;
        outp_prdata = $urandom;
        wseen++;
      end else begin
        outp_pready = 1'b1;
        outp_prdata = pd;
      end
    end
    if (outp_psel || outp_penable || req_ready) ok = 1'b0;
    rd  = rsp_rdata;
    err = rsp_err;
    outp_pready = 1'($urandom_range(0, 1));
    outp_prdata = $urandom;
    rsp_ready   = 1'b0;
    req_valid   = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      step();
      if (!rsp_valid || rsp_rdata !== rd || rsp_err !== err || req_ready || outp_psel) ok = 1'b0;
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    outp_pready = 1'b0;
    if (rsp_valid || !req_ready || rsp_err) ok = 1'b0;
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] prdata;
    int            waits;
    int            hold;
    logic [DW-1:0] exp_rdata;
    int            exp_lat;
    logic          exp_err;
  } vec_t;

  vec_t vt[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] rd;
    int            lat;
    logic          err;
    logic          ok;
    int            acc;
    int            prev_acc;
    exp_t          e;
    logic          seen;

    //          wr    addr          wdata          prdata        waits hold exp_rdata     lat err
    vt[0] = '{1'b0, 32'h0000_1000, 32'h0,        32'hDEAD_BEEF, 0,  0, 32'hDEAD_BEEF, 2, 1'b0};
    vt[1] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 32'hCAFE_F00D, 3,  0, 32'h0,        5, 1'b0};
    vt[2] = '{1'b0, 32'h0000_0004, 32'h5555_5555, 32'h0,        1,  0, 32'h0,        3, 1'b0};
    vt[3] = '{1'b0, 32'hFFFF_FFFC, 32'h0,        32'hA5A5_5A5A, 2,  5, 32'hA5A5_5A5A, 4, 1'b0};
    vt[4] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1111_1111, 0,  0, 32'h0,        2, 1'b0};
    vt[5] = '{1'b0, 32'h0000_0008, 32'h0,        32'h0000_0001, 0,  5, 32'h0000_0001, 2, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; outp_pready = 1'b0; outp_prdata = '0;
    step(); step();
    rst = 1'b0;
    step();
    chk("reset_ctrl", {outp_psel, outp_penable, outp_pwrite, rsp_valid, rsp_err, req_ready}, 6'b000001);
    chk("reset_paddr", outp_paddr, 32'h0);
    chk("reset_pwdata", outp_pwdata, 32'h0);
    chk("reset_rdata", rsp_rdata, 32'h0);

    // Vector table: back-to-back transfers, so spacing follows latency + hold.
    prev_acc = 0;
    for (int i = 0; i < 6; i++) begin
      xfer(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].waits, vt[i].prdata, vt[i].hold,
           rd, lat, err, ok, acc);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].exp_lat);
      chk($sformatf("vec%0d_err", i), err, vt[i].exp_err);
      chk($sformatf("vec%0d_protocol", i), ok, 1'b1);
      chk($sformatf("vec%0d_idle_paddr", i), outp_paddr, vt[i].addr);
      if (i > 0)
        chk($sformatf("vec%0d_spacing", i), acc - prev_acc, vt[i-1].exp_lat + vt[i-1].hold + 2);
      prev_acc = acc;
    end

    // Reset while in ACCESS: transfer vanishes, no response afterwards.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; req_wdata = '0; outp_pready = 1'b0;
    step();
    req_valid = 1'b0;
    step();
    chk("rst_access_pre", {outp_psel, outp_penable}, 2'b11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_access_post", {outp_psel, outp_penable, rsp_valid, req_ready}, 4'b0001);
    outp_pready = 1'b1; outp_prdata = 32'hBAD0_BAD0; rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rsp_valid || outp_psel) seen = 1'b1;
    end
    chk("rst_access_no_rsp", seen, 1'b0);
    rsp_ready = 1'b0; outp_pready = 1'b0;

`ifdef APB_TIMEOUT_EN
    // pready never arrives within the limit: abort with error.
    xfer(1'b0, 32'h100, 32'h0, 10, 32'h7777_7777, 1, rd, lat, err, ok, acc);
    chk("timeout_err", err, 1'b1);
    chk("timeout_rdata", rd, 32'h0);
    chk("timeout_lat", lat, 1 + TO);
    chk("timeout_protocol", ok, 1'b1);
    // pready on the same edge as the limit: completion wins.
    xfer(1'b0, 32'h104, 32'h0, TO - 1, 32'h7777_7777, 0, rd, lat, err, ok, acc);
    chk("limit_edge_err", err, 1'b0);
    chk("limit_edge_rdata", rd, 32'h7777_7777);
    chk("limit_edge_lat", lat, 1 + TO);
`endif

    // Random transfers against the model.
    for (int i = 0; i < 40; i++) begin
      logic          wr;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [DW-1:0] pd;
      int            w;
      int            h;
      wr = 1'($urandom_range(0, 1));
      a  = $urandom;
      d  = $urandom;
      pd = $urandom;
      w  = int'($urandom_range(0, 6));
      h  = int'($urandom_range(0, 3));
      e  = model(wr, pd, w);
      xfer(wr, a, d, w, pd, h, rd, lat, err, ok, acc);
      chk($sformatf("rnd%0d_rdata", i), rd, e.rdata);
      chk($sformatf("rnd%0d_lat", i), lat, e.lat);
      chk($sformatf("rnd%0d_err", i), err, e.err);
      chk($sformatf("rnd%0d_protocol", i), ok, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
